// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_SEG_W = 8;
    localparam int CLA_MAX_W = 64;

    typedef logic [CLA_SEG_W-1:0] seg_t;

    // Per-stage control; the operand and partial-sum vectors shrink/grow per stage and live beside it.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sign_a;
        logic sign_b;
    } stage_t;

    // Saturation bound for a w-bit result: max positive when sign=0, min negative when sign=1.
    function automatic logic [CLA_MAX_W-1:0] sat_val(input logic sign, input int unsigned w);
        logic [CLA_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CLA_MAX_W; i++) begin
            if (i + 1 < w) begin
                r[i] = ~sign;
            end else if (i + 1 == w) begin
                r[i] = sign;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder; slave is the adder, master the producer/consumer.
interface cla_pipe_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    modport master (
        output in_valid, a_i, b_i, cin_i, sub_i, out_ready,
        input  in_ready, out_valid, sum_o, cout_o, ovf_o
    );

    modport slave (
        input  in_valid, a_i, b_i, cin_i, sub_i, out_ready,
        output in_ready, out_valid, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/cla_slice.sv
// Combinational SEG_W-bit carry-lookahead slice; carry out of the slice is G | (P & cin).
module cla_slice #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] s_o,
    output logic             g_o,
    output logic             p_o
);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] c;
    logic             g_acc;
    logic             p_acc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry is the flattened sum-of-products over all lower generates, not a ripple chain.
    always_comb begin
        c     = '0;
        c[0]  = cin_i;
        g_acc = 1'b0;
        p_acc = 1'b1;
        for (int i = 0; i < SEG_W; i++) begin
            g_acc = g[i];
            p_acc = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                g_acc = g_acc | (p_acc & g[j]);
                p_acc = p_acc & p[j];
            end
            if (i < SEG_W - 1) begin
                c[i + 1] = g_acc | (p_acc & cin_i);
            end
        end
        g_o = g_acc;
        p_o = p_acc;
    end

    assign s_o = p ^ c;
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit CLA adder/subtractor, one SEG_W slice per stage, carry registered between stages.
// Define CLA_SAT_EN to saturate the result on signed overflow (applied in the last stage).
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int SEG_W = CLA_SEG_W
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_W;

    if ((SEG_W < 1) || (SEG_W > WIDTH) || (WIDTH % SEG_W != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a positive multiple of SEG_W");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    logic             out_vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Subtraction as A + ~B + ~borrow, so the stages only ever add.
    assign b_eff = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign c_in  = bus.sub_i ? ~bus.cin_i : bus.cin_i;

    assign en           = !out_vld_q || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_vld_q;
    assign bus.sum_o    = sum_q;
    assign bus.cout_o   = cout_q;
    assign bus.ovf_o    = ovf_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG_W-1:0] sa;
        logic [SEG_W-1:0] sb;
        logic [SEG_W-1:0] s;
        logic             g;
        logic             p;
        logic             cout;
        stage_t           ctl;

        if (k == 0) begin : g_src
            assign sa  = bus.a_i[SEG_W-1:0];
            assign sb  = b_eff[SEG_W-1:0];
            assign ctl = '{valid: bus.in_valid, carry: c_in,
                           sign_a: bus.a_i[WIDTH-1], sign_b: b_eff[WIDTH-1]};
        end else begin : g_src
            assign sa  = g_stage[k-1].g_mid.a_rem_q[SEG_W-1:0];
            assign sb  = g_stage[k-1].g_mid.b_rem_q[SEG_W-1:0];
            assign ctl = g_stage[k-1].g_mid.ctl_q;
        end

        cla_slice #(.SEG_W(SEG_W)) u_slice (
            .a_i   (sa),
            .b_i   (sb),
            .cin_i (ctl.carry),
            .s_o   (s),
            .g_o   (g),
            .p_o   (p)
        );

        assign cout = g | (p & ctl.carry);

        if (k < NSEG - 1) begin : g_mid
            localparam int REM = WIDTH - (k + 1) * SEG_W;
            localparam int LOW = (k + 1) * SEG_W;

            stage_t           ctl_q;
            logic [REM-1:0]   a_rem_q;
            logic [REM-1:0]   b_rem_q;
            logic [LOW-1:0]   lo_q;
            logic [REM-1:0]   a_rem_d;
            logic [REM-1:0]   b_rem_d;
            logic [LOW-1:0]   lo_d;

            if (k == 0) begin : g_first
                assign a_rem_d = bus.a_i[WIDTH-1:SEG_W];
                assign b_rem_d = b_eff[WIDTH-1:SEG_W];
                assign lo_d    = s;
            end else begin : g_next
                assign a_rem_d = g_stage[k-1].g_mid.a_rem_q[REM+SEG_W-1:SEG_W];
                assign b_rem_d = g_stage[k-1].g_mid.b_rem_q[REM+SEG_W-1:SEG_W];
                assign lo_d    = {s, g_stage[k-1].g_mid.lo_q};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ctl_q   <= '0;
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                    lo_q    <= '0;
                end else if (en) begin
                    ctl_q   <= '{valid: ctl.valid, carry: cout,
                                 sign_a: ctl.sign_a, sign_b: ctl.sign_b};
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                    lo_q    <= lo_d;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] wrap_d;
            logic [WIDTH-1:0] sum_d;
            logic             ovf_d;

            if (k == 0) begin : g_only
                assign wrap_d = s;
            end else begin : g_join
                assign wrap_d = {s, g_stage[k-1].g_mid.lo_q};
            end

            assign ovf_d = (ctl.sign_a == ctl.sign_b) && (wrap_d[WIDTH-1] != ctl.sign_a);
`ifdef CLA_SAT_EN
            assign sum_d = ovf_d ? WIDTH'(sat_val(ctl.sign_a, WIDTH)) : wrap_d;
`else
            assign sum_d = wrap_d;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_vld_q <= 1'b0;
                    sum_q     <= '0;
                    cout_q    <= 1'b0;
                    ovf_q     <= 1'b0;
                end else if (en) begin
                    out_vld_q <= ctl.valid;
                    sum_q     <= sum_d;
                    cout_q    <= cout;
                    ovf_q     <= ovf_d;
                end
            end
        end
    end
endmodule
